// File: rtl/player_move_ctrl.sv
// Turn and movement sequencer for two board tokens on a serpentine tile path.
// Hops the current player one tile per STEP_FRAMES frame ticks and drives both sprite positions.
module player_move_ctrl #(
    parameter int COLS        = 8,
    parameter int ROWS        = 4,
    parameter int TILE_PX     = 32,
    parameter int ORIGIN_X    = 64,
    parameter int ORIGIN_Y    = 48,
    parameter int STEP_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [2:0] dice,
    input  logic       game_reset,
    output logic [9:0] p1_x,
    output logic [9:0] p1_y,
    output logic [9:0] p2_x,
    output logic [9:0] p2_y,
    output logic       turn,
    output logic       busy,
    output logic       done,
    output logic       won,
    output logic       winner,
    output logic       top_id
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    // The path ends on the right if the top row runs left to right, else on the left.
    localparam logic [CW-1:0] END_COL = (((ROWS - 1) % 2) == 0) ? COL_MAX : '0;
    localparam logic [FW-1:0] TICK_LAST = FW'(STEP_FRAMES - 1);

    localparam logic [9:0] X1_RST = 10'(ORIGIN_X);
    localparam logic [9:0] X2_RST = 10'(ORIGIN_X + 16);
    localparam logic [9:0] Y_RST  = 10'(ORIGIN_Y + (ROWS - 1) * TILE_PX + 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HOP,
        S_FINISH,
        S_WIN,
        S_DONE_WIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q [2];
    logic [CW-1:0] col_d [2];
    logic [RW-1:0] row_q [2];
    logic [RW-1:0] row_d [2];
    logic          turn_q;
    logic          mover_q;
    logic [2:0]    steps_q;
    logic [FW-1:0] tick_cnt;
    logic [CW-1:0] hop_col;
    logic [RW-1:0] hop_row;
    logic          hop_is_last;

    function automatic logic [9:0] x_of(input logic [CW-1:0] c, input logic p2);
        return 10'(ORIGIN_X + int'(c) * TILE_PX + (p2 ? 16 : 0));
    endfunction

    function automatic logic [9:0] y_of(input logic [RW-1:0] r);
        return 10'(ORIGIN_Y + (ROWS - 1 - int'(r)) * TILE_PX + 8);
    endfunction

    // Serpentine step for the moving token: along the row, or up at the row end.
    always_comb begin
        hop_col = col_q[mover_q];
        hop_row = row_q[mover_q];
        if (!row_q[mover_q][0] && col_q[mover_q] != COL_MAX) begin
            hop_col = col_q[mover_q] + 1'b1;
        end else if (row_q[mover_q][0] && col_q[mover_q] != '0) begin
            hop_col = col_q[mover_q] - 1'b1;
        end else begin
            hop_row = row_q[mover_q] + 1'b1;
        end
        hop_is_last = (hop_row == ROW_MAX) && (hop_col == END_COL);
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == S_HOP) begin
            col_d[mover_q] = hop_col;
            row_d[mover_q] = hop_row;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start && dice != 3'd0 && dice != 3'd7) state_d = S_WAIT;
            S_WAIT:     if (frame_tick && tick_cnt == TICK_LAST) state_d = S_HOP;
            S_HOP: begin
                if (hop_is_last)          state_d = S_WIN;
                else if (steps_q == 3'd1) state_d = S_FINISH;
                else                      state_d = S_WAIT;
            end
            S_FINISH:   state_d = S_IDLE;
            S_WIN:      state_d = S_DONE_WIN;
            S_DONE_WIN: state_d = S_DONE_WIN;
            default:    state_d = S_IDLE;
        endcase
        if (game_reset) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            col_q    <= '{default: '0};
            row_q    <= '{default: '0};
            turn_q   <= 1'b0;
            mover_q  <= 1'b0;
            steps_q  <= '0;
            tick_cnt <= '0;
            p1_x     <= X1_RST;
            p1_y     <= Y_RST;
            p2_x     <= X2_RST;
            p2_y     <= Y_RST;
        end else if (game_reset) begin
            state_q  <= S_IDLE;
            col_q    <= '{default: '0};
            row_q    <= '{default: '0};
            turn_q   <= 1'b0;
            mover_q  <= 1'b0;
            steps_q  <= '0;
            tick_cnt <= '0;
            p1_x     <= X1_RST;
            p1_y     <= Y_RST;
            p2_x     <= X2_RST;
            p2_y     <= Y_RST;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            // Coordinates follow the post-hop tile so they appear with done.
            p1_x    <= x_of(col_d[0], 1'b0);
            p1_y    <= y_of(row_d[0]);
            p2_x    <= x_of(col_d[1], 1'b1);
            p2_y    <= y_of(row_d[1]);
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_WAIT) begin
                        mover_q  <= turn_q;
                        steps_q  <= dice;
                        tick_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    if (frame_tick) tick_cnt <= (state_d == S_HOP) ? '0 : tick_cnt + 1'b1;
                end
                S_HOP: begin
                    steps_q <= steps_q - 1'b1;
                    if (state_d == S_FINISH) turn_q <= ~turn_q;
                end
                default: ;
            endcase
        end
    end

    assign turn   = turn_q;
    assign busy   = (state_q == S_WAIT) || (state_q == S_HOP);
    assign done   = (state_q == S_FINISH) || (state_q == S_WIN);
    assign won    = (state_q == S_WIN) || (state_q == S_DONE_WIN);
    assign winner = won & mover_q;
    assign top_id = busy ? mover_q : turn_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: path-index reference model compared every cycle,
// plus hand-computed position, turn and win checkpoints.
module tb_player_move_ctrl;

    localparam int COLS        = 8;
    localparam int ROWS        = 4;
    localparam int TILE_PX     = 32;
    localparam int ORIGIN_X    = 64;
    localparam int ORIGIN_Y    = 48;
    localparam int STEP_FRAMES = 2;
    localparam int LAST        = COLS * ROWS - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [2:0] dice = 3'd0;
    logic       game_reset = 1'b0;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       turn, busy, done, won, winner, top_id;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;

    player_move_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .TILE_PX(TILE_PX),
        .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .STEP_FRAMES(STEP_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
        .dice(dice), .game_reset(game_reset),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .turn(turn), .busy(busy), .done(done), .won(won), .winner(winner), .top_id(top_id)
    );

    always #5 clk = ~clk;

    // Reference model: each token is a path index 0..LAST; screen position derived by division.
    int m_pos [2] = '{0, 0};
    bit m_busy = 0, m_done = 0, m_won = 0, m_winner = 0, m_turn = 0, m_mover = 0, m_hop = 0;
    int m_ticks = 0, m_left = 0;

    function automatic int exp_x(input int idx, input bit p2);
        int r, c;
        r = idx / COLS;
        c = idx % COLS;
        if (r % 2 == 1) c = COLS - 1 - c;
        return ORIGIN_X + c * TILE_PX + (p2 ? 16 : 0);
    endfunction

    function automatic int exp_y(input int idx);
        return ORIGIN_Y + (ROWS - 1 - idx / COLS) * TILE_PX + 8;
    endfunction

    task automatic model_reset();
        m_pos = '{0, 0};
        m_busy = 0; m_done = 0; m_won = 0; m_winner = 0;
        m_turn = 0; m_mover = 0; m_hop = 0; m_ticks = 0; m_left = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit was_done;
        if (!rst_n || game_reset) begin
            model_reset();
        end else begin
            was_done = m_done;
            m_done = 0;
            if (m_hop) begin
                m_hop = 0;
                m_pos[m_mover] = m_pos[m_mover] + 1;
                m_left = m_left - 1;
                if (m_pos[m_mover] == LAST) begin
                    m_busy = 0; m_done = 1; m_won = 1; m_winner = m_mover;
                end else if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_turn = !m_turn;
                end
            end else if (m_busy) begin
                if (frame_tick) begin
                    m_ticks = m_ticks + 1;
                    if (m_ticks == STEP_FRAMES) begin
                        m_hop = 1;
                        m_ticks = 0;
                    end
                end
            end else if (!was_done && !m_won && start && dice >= 3'd1 && dice <= 3'd6) begin
                m_busy = 1; m_mover = m_turn; m_left = int'(dice); m_ticks = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("cyc_p1_x", p1_x, exp_x(m_pos[0], 0));
        checkOutput("cyc_p1_y", p1_y, exp_y(m_pos[0]));
        checkOutput("cyc_p2_x", p2_x, exp_x(m_pos[1], 1));
        checkOutput("cyc_p2_y", p2_y, exp_y(m_pos[1]));
        checkOutput("cyc_turn", turn, m_turn);
        checkOutput("cyc_busy", busy, m_busy);
        checkOutput("cyc_done", done, m_done);
        checkOutput("cyc_won", won, m_won);
        checkOutput("cyc_winner", winner, m_winner);
        checkOutput("cyc_top_id", top_id, m_busy ? m_mover : m_turn);
        if (done) n_done++;
    end

    task automatic applyStimulus(input logic ft, input logic st, input logic [2:0] d, input logic gr);
        frame_tick = ft;
        start      = st;
        dice       = d;
        game_reset = gr;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        dice       = 3'd0;
        game_reset = 1'b0;
    endtask

    task automatic do_move(input int d, input logic who, input logic restart);
        applyStimulus(1'b0, 1'b1, 3'(d), 1'b0);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("top_id_busy", top_id, who);
        for (int f = 0; f < 40 && m_busy; f++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            if (restart && f == 0) applyStimulus(1'b0, 1'b1, 3'd6, 1'b0);
            else                   applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        end
        checkOutput("move_settled", busy, 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        int hop_x [3] = '{96, 128, 160};
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        $display("[TB] reset state");
        checkOutput("rst_p1_x", p1_x, 64);
        checkOutput("rst_p1_y", p1_y, 152);
        checkOutput("rst_p2_x", p2_x, 80);
        checkOutput("rst_p2_y", p2_y, 152);
        checkOutput("rst_turn", turn, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_won", won, 0);

        $display("[TB] P1 dice 3");
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0);
        for (int f = 1; f <= 6; f++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
            if (f % 2 == 0) checkOutput("p1_x_hop", p1_x, hop_x[f/2-1]);
        end
        checkOutput("t1_done_count", n_done, 1);
        checkOutput("t1_turn", turn, 1);
        checkOutput("t1_p2_x", p2_x, 80);
        checkOutput("t1_p2_y", p2_y, 152);

        $display("[TB] row wrap");
        do_move(2, 1'b1, 1'b0);
        checkOutput("p2_after_2", p2_x, 144);
        checkOutput("top_id_after_p2", top_id, 0);
        do_move(4, 1'b0, 1'b0);
        checkOutput("p1_x_col7", p1_x, 288);
        checkOutput("p1_y_row0", p1_y, 152);
        do_move(1, 1'b1, 1'b0);
        do_move(1, 1'b0, 1'b0);
        checkOutput("wrap_p1_x", p1_x, 288);
        checkOutput("wrap_p1_y", p1_y, 120);
        do_move(1, 1'b1, 1'b0);
        do_move(1, 1'b0, 1'b0);
        checkOutput("odd_p1_x", p1_x, 256);
        checkOutput("odd_p1_y", p1_y, 120);

        $display("[TB] invalid and overlapping requests");
        applyStimulus(1'b0, 1'b1, 3'd0, 1'b0);
        checkOutput("dice0_busy", busy, 0);
        applyStimulus(1'b0, 1'b1, 3'd7, 1'b0);
        checkOutput("dice7_busy", busy, 0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("invalid_p2_x", p2_x, 208);
        do_move(2, 1'b1, 1'b1);
        checkOutput("overlap_p2_x", p2_x, 272);
        checkOutput("overlap_turn", turn, 0);

        $display("[TB] approach the last tile");
        do_move(1, 1'b0, 1'b0);
        do_move(6, 1'b1, 1'b0);
        do_move(1, 1'b0, 1'b0);
        do_move(6, 1'b1, 1'b0);
        do_move(1, 1'b0, 1'b0);
        do_move(6, 1'b1, 1'b0);
        do_move(1, 1'b0, 1'b0);
        do_move(5, 1'b1, 1'b0);
        do_move(1, 1'b0, 1'b0);
        checkOutput("pre_win_p2_x", p2_x, 144);
        checkOutput("pre_win_p2_y", p2_y, 56);
        checkOutput("pre_win_p1_x", p1_x, 96);

        $display("[TB] clamp and win");
        do_move(5, 1'b1, 1'b0);
        checkOutput("win_p2_x", p2_x, 80);
        checkOutput("win_p2_y", p2_y, 56);
        checkOutput("win_won", won, 1);
        checkOutput("win_winner", winner, 1);
        checkOutput("win_turn", turn, 1);
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0);
        checkOutput("post_win_busy", busy, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("post_win_p1_x", p1_x, 96);
        checkOutput("post_win_won", won, 1);

        $display("[TB] game_reset");
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b1);
        checkOutput("grst_won", won, 0);
        checkOutput("grst_p2_x", p2_x, 80);
        checkOutput("grst_p2_y", p2_y, 152);
        checkOutput("grst_p1_x", p1_x, 64);
        checkOutput("grst_turn", turn, 0);
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b1);
        checkOutput("grst_start_busy", busy, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("grst_start_p1_x", p1_x, 64);

        $display("[TB] async reset mid-move");
        do_move(2, 1'b0, 1'b0);
        checkOutput("pre_arst_p1_x", p1_x, 128);
        applyStimulus(1'b0, 1'b1, 3'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_p1_x", p1_x, 64);
        checkOutput("arst_p2_x", p2_x, 80);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_turn", turn, 0);
        checkOutput("arst_top_id", top_id, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Turn and movement sequencer for the two board tokens drawn by the 16x16 player sprite renderers. It accepts a dice result for the player whose turn it is and advances that token one tile at a time along a serpentine board path, paced by frame ticks. It drives the pixel coordinates consumed by both renderer instances and reports the turn, busy, win and draw-priority status to the game logic and the compositor.

## Interface
- COLS, 8, tiles per board row
- ROWS, 4, board rows; path length COLS*ROWS tiles (index 0..COLS*ROWS-1)
- TILE_PX, 32, tile pitch in pixels
- ORIGIN_X, 64, screen x of the board's left edge
- ORIGIN_Y, 48, screen y of the board's top edge
- STEP_FRAMES, 2, frame ticks per one-tile hop (>=1)
- clk  in  1  pixel/system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame (vsync)
- start  in  1  one-cycle request: move the current player by dice
- dice  in  3  dice value; valid range 1..6
- game_reset  in  1  synchronous: return to the reset state
- p1_x, p1_y, p2_x, p2_y  out  10 each  sprite top-left coordinates
- turn  out  1  player to move next (0=P1, 1=P2)
- busy  out  1  move in progress
- done  out  1  one-cycle pulse when a move completes
- won  out  1  a player has reached the last tile
- winner  out  1  winning player; valid while won=1
- top_id  out  1  player to draw on top

## Operation
- Per-player state: col (0..COLS-1) and row (0..ROWS-1). No path index is stored and no divider is used.
- Row 0 is the bottom row. Even rows run left to right; odd rows run right to left.
- One hop:
  - Even row, col<COLS-1: col+1.
  - Odd row, col>0: col-1.
  - Otherwise: row+1, col unchanged.
- Last tile: row=ROWS-1 and col equal to the row's end (COLS-1 if ROWS-1 is even, else 0).
- Coordinates:
  - x = ORIGIN_X + col*TILE_PX + (P2 ? 16 : 0)
  - y = ORIGIN_Y + (ROWS-1-row)*TILE_PX + 8
  - Coordinates are registered. They update the cycle after the hop.
- States:
  - IDLE
    - start with dice in 1..6 and won=0: latch mover=turn and steps=dice, then go to WAIT.
    - Any other start (dice 0 or 7, or won=1) is ignored.
  - WAIT: count frame_ticks. On the STEP_FRAMES-th tick go to HOP.
  - HOP: advance the mover one tile and decrement steps.
    - Mover now on the last tile: go to WIN.
    - Else steps==0: go to FINISH.
    - Else: return to WAIT with the tick counter cleared.
  - FINISH: done=1 for one cycle, turn toggles, go to IDLE.
  - WIN: done=1 for one cycle, won=1, winner=mover, turn unchanged. Then stay in DONE_WIN until game_reset.
- Overshoot clamps: remaining steps are discarded at the last tile.
- start while busy is ignored.
- Tokens may share a tile. The 16 px x offset keeps both visible.
- busy=1 in WAIT and HOP.
- top_id = mover while busy, else turn.
- Reset (rst_n low or game_reset=1):
  - State IDLE, both tokens at col 0, row 0, turn 0.
  - busy, done, won, winner all 0.
  - With defaults: p1=(64,152), p2=(80,152).
  - Reset mid-move abandons the move immediately.
  - game_reset has priority over start in the same cycle.

## Timing
- start sampled in IDLE at cycle T: busy=1 at T+1.
- A frame_tick in cycle T itself is not counted. Ticks are counted from T+1.
- The hop is applied the cycle after the qualifying tick. The new coordinates are visible the following cycle.
- After the last hop: done pulses one cycle later, and busy falls in the same cycle as done.
- turn toggles in the same cycle as done.
- frame_tick outside WAIT is ignored.
- Move duration: dice*STEP_FRAMES frame ticks plus a constant of at most 3 cycles.

## Test plan
- Reset, then P1 start with dice=3 and 6 frame ticks:
  - p1_x steps 64 → 96 → 128 → 160 (one hop per 2 ticks).
  - done pulses once, turn=1, p2 unchanged at (80,152).
- Row wrap: P1 at col 7, row 0, dice=1:
  - p1=(288,120), i.e. row 1, col 7.
  - Next dice=1: p1=(256,120).
- Clamp/win: P2 two tiles from the end, dice=5:
  - Exactly 2 hops, p2=(80,56), then won=1, winner=1, turn stays 1.
  - Further starts are ignored until game_reset.
- Invalid and overlapping requests:
  - dice=0 or dice=7 produces no busy and no motion.
  - start during busy leaves steps unchanged, giving only the original dice count of hops.
- Reset mid-move:
  - rst_n low during WAIT: all outputs return to reset values asynchronously.
  - Repeat with game_reset asserted together with start: reset wins, busy stays 0.
- top_id:
  - During P2's move top_id=1.
  - After P2's move completes (turn→0), top_id=0.
